// File: rtl/cache_assoc_pkg.sv
// rtl/cache_assoc_pkg.sv - shared defaults and width helpers for the set-associative cache array
package cache_assoc_pkg;

    localparam int DEF_ADDR_BITS  = 32;
    localparam int DEF_WORD_BITS  = 32;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_SET_NUM    = 64;
    localparam int DEF_LINE_WORDS = 4;

    // A one-way cache still needs a 1-bit way index on the ports.
    function automatic int bits_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_assoc_lru.sv
// rtl/cache_assoc_lru.sv - true-LRU age counters for one cache set
module cache_lru
    import cache_assoc_pkg::*;
#(
    parameter  int WAYS = DEF_WAYS,
    localparam int WB   = bits_min1(WAYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          touch,
    input  logic [WB-1:0] touch_way,
    input  logic          demote,
    input  logic [WB-1:0] demote_way,
    output logic [WB-1:0] lru_way
);

    logic [WB-1:0] age_q [WAYS];
    logic [WB-1:0] age_d [WAYS];
    logic [WB-1:0] ref_age;

    // Ages stay a permutation: touching moves a way to 0, demoting moves it to WAYS-1.
    always_comb begin
        age_d   = age_q;
        ref_age = touch ? age_q[touch_way] : age_q[demote_way];
        for (int w = 0; w < WAYS; w++) begin
            if (touch) begin
                if (WB'(w) == touch_way)
                    age_d[w] = '0;
                else if (age_q[w] < ref_age)
                    age_d[w] = age_q[w] + 1'b1;
            end else if (demote) begin
                if (WB'(w) == demote_way)
                    age_d[w] = WB'(WAYS - 1);
                else if (age_q[w] > ref_age)
                    age_d[w] = age_q[w] - 1'b1;
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (age_q[w] == WB'(WAYS - 1))
                lru_way = WB'(w);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++)
                age_q[w] <= WB'(w);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cache_assoc.sv
// rtl/cache_assoc.sv - N-way set-associative cache storage with true-LRU, byte writes and victim report
module cache_assoc
    import cache_assoc_pkg::*;
#(
    parameter  int ADDR_BITS  = DEF_ADDR_BITS,
    parameter  int WORD_BITS  = DEF_WORD_BITS,
    parameter  int WAYS       = DEF_WAYS,
    parameter  int SET_NUM    = DEF_SET_NUM,
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    localparam int OFS_BITS   = $clog2(LINE_WORDS),
    localparam int IDX_BITS   = $clog2(SET_NUM),
    localparam int TAG_BITS   = ADDR_BITS - IDX_BITS - OFS_BITS - 2,
    localparam int WB         = bits_min1(WAYS),
    localparam int NB         = WORD_BITS / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 read,
    input  logic                 load,
    input  logic                 edit,
    input  logic                 invalid,
    input  logic [NB-1:0]        wstrb,
    input  logic [WORD_BITS-1:0] din,
    output logic                 hit,
    output logic [WB-1:0]        hit_way,
    output logic [WB-1:0]        victim_way,
    output logic [WORD_BITS-1:0] dout,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag
);

    logic [WORD_BITS-1:0] data_q  [SET_NUM][WAYS][LINE_WORDS];
    logic [TAG_BITS-1:0]  tag_q   [SET_NUM][WAYS];
    logic [WAYS-1:0]      valid_q [SET_NUM];
    logic [WAYS-1:0]      dirty_q [SET_NUM];
    logic [WB-1:0]        lru_way_s [SET_NUM];

    logic [TAG_BITS-1:0]  addr_tag;
    logic [IDX_BITS-1:0]  idx;
    logic [OFS_BITS-1:0]  ofs;
    logic                 unused_byte_ofs;
    logic                 inv_found;
    logic [WB-1:0]        sel_way;
    logic [WB-1:0]        tgt_way;
    logic                 do_inv, do_load, do_edit, do_read, touch;

    assign addr_tag        = addr[ADDR_BITS-1 -: TAG_BITS];
    assign idx             = addr[OFS_BITS+2 +: IDX_BITS];
    assign ofs             = addr[2 +: OFS_BITS];
    assign unused_byte_ofs = ^addr[1:0];

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        victim_way = lru_way_s[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == addr_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found  = 1'b1;
                victim_way = WB'(w);
            end
        end
    end

    assign sel_way = hit ? hit_way : victim_way;
    assign valid   = valid_q[idx][sel_way];
    assign dirty   = dirty_q[idx][sel_way];
    assign tag     = valid ? tag_q[idx][sel_way] : '0;
    assign dout    = hit ? data_q[idx][hit_way][ofs] : '0;
    assign tgt_way = sel_way;

    // The highest raised strobe wins even when it then has nothing to do on a miss.
    assign do_inv  = invalid && hit;
    assign do_load = !invalid && load;
    assign do_edit = !invalid && !load && edit && hit;
    assign do_read = !invalid && !load && !edit && read && hit;
    assign touch   = do_load || do_edit || do_read;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (do_inv) begin
            valid_q[idx][hit_way] <= 1'b0;
            dirty_q[idx][hit_way] <= 1'b0;
        end else if (do_load) begin
            valid_q[idx][tgt_way] <= 1'b1;
            dirty_q[idx][tgt_way] <= 1'b0;
        end else if (do_edit) begin
            dirty_q[idx][hit_way] <= 1'b1;
        end
    end

    // Contents are meaningless while the way is invalid, so these arrays carry no reset.
    always_ff @(posedge clk) begin
        if (do_load) begin
            data_q[idx][tgt_way][ofs] <= din;
            tag_q[idx][tgt_way]       <= addr_tag;
        end else if (do_edit) begin
            for (int b = 0; b < NB; b++)
                if (wstrb[b])
                    data_q[idx][hit_way][ofs][b*8 +: 8] <= din[b*8 +: 8];
        end
    end

    for (genvar s = 0; s < SET_NUM; s++) begin : g_set
        cache_lru #(.WAYS(WAYS)) u_lru (
            .clk        (clk),
            .rst        (rst),
            .touch      (touch && idx == IDX_BITS'(s)),
            .touch_way  (tgt_way),
            .demote     (do_inv && idx == IDX_BITS'(s)),
            .demote_way (hit_way),
            .lru_way    (lru_way_s[s])
        );
    end

endmodule

// File: tb/tb_cache_assoc.sv
// tb/tb_cache_assoc.sv - scoreboard bench for cache_assoc with default geometry
module tb_cache_assoc;

    localparam int F_HIT = 0, F_HWAY = 1, F_VWAY = 2, F_DOUT = 3, F_VALID = 4, F_DIRTY = 5, F_TAG = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        read, load, edit, invalid;
    logic [3:0]  wstrb;
    logic [31:0] din;
    logic        hit;
    logic [0:0]  hit_way, victim_way;
    logic [31:0] dout;
    logic        valid, dirty;
    logic [21:0] tag;

    typedef struct {
        string       name;
        logic [31:0] a;
        int          field;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_assoc dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .read       (read),
        .load       (load),
        .edit       (edit),
        .invalid    (invalid),
        .wstrb      (wstrb),
        .din        (din),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .dout       (dout),
        .valid      (valid),
        .dirty      (dirty),
        .tag        (tag)
    );

    function automatic logic [31:0] observe(input int f);
        case (f)
            F_HIT:   return {31'd0, hit};
            F_HWAY:  return {31'd0, hit_way};
            F_VWAY:  return {31'd0, victim_way};
            F_DOUT:  return dout;
            F_VALID: return {31'd0, valid};
            F_DIRTY: return {31'd0, dirty};
            F_TAG:   return {10'd0, tag};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void push_exp(input string n, input logic [31:0] a, input int f, input logic [31:0] v);
        exp_t x;
        x.name = n; x.a = a; x.field = f; x.exp = v;
        sb.push_back(x);
    endfunction

    task automatic op(input logic r, l, ed, inv, input logic [31:0] a, d, input logic [3:0] s);
        @(negedge clk);
        addr = a; din = d; wstrb = s;
        read = r; load = l; edit = ed; invalid = inv;
        @(posedge clk);
        #1;
        read = 0; load = 0; edit = 0; invalid = 0;
    endtask

    task automatic test_reset();
        read = 0; load = 0; edit = 0; invalid = 0; wstrb = 0; din = 0; addr = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        push_exp("rst_hit", 32'h0, F_HIT, 0);
        push_exp("rst_valid", 32'h0, F_VALID, 0);
        push_exp("rst_dirty", 32'h0, F_DIRTY, 0);
        push_exp("rst_tag", 32'h0, F_TAG, 0);
        push_exp("rst_victim", 32'h0, F_VWAY, 0);
        push_exp("rst_dout", 32'h0, F_DOUT, 0);
        push_exp("rst_hit_way", 32'h0, F_HWAY, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
    endtask

    task automatic test_fills();
        for (int i = 0; i < 4; i++) op(0, 1, 0, 0, 32'h0 + 4 * i, 32'h11111111, 4'h0);
        push_exp("fill1_hit", 32'h8, F_HIT, 1);
        push_exp("fill1_way", 32'h8, F_HWAY, 0);
        push_exp("fill1_dout", 32'h8, F_DOUT, 32'h11111111);
        push_exp("fill1_dirty", 32'h8, F_DIRTY, 0);
        for (int i = 0; i < 4; i++) op(0, 1, 0, 0, 32'h400 + 4 * i, 32'h22222222, 4'h0);
        push_exp("fill2_way", 32'h40C, F_HWAY, 1);
        push_exp("fill2_dout", 32'h40C, F_DOUT, 32'h22222222);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
        op(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        push_exp("rd0_hit", 32'h0, F_HIT, 1);
        push_exp("rd0_way", 32'h0, F_HWAY, 0);
        push_exp("miss800_hit", 32'h800, F_HIT, 0);
        push_exp("miss800_victim", 32'h800, F_VWAY, 1);
        push_exp("miss800_valid", 32'h800, F_VALID, 1);
        push_exp("miss800_tag", 32'h800, F_TAG, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
    endtask

    task automatic test_edit();
        op(0, 0, 1, 0, 32'h4, 32'hAAAAAAAA, 4'b0011);
        push_exp("edit_dout", 32'h4, F_DOUT, 32'h1111AAAA);
        push_exp("edit_dirty", 32'h4, F_DIRTY, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
        op(1, 0, 0, 0, 32'h400, 32'h0, 4'h0);
        op(0, 0, 1, 0, 32'h804, 32'hFFFFFFFF, 4'hF);
        push_exp("lru_victim", 32'h800, F_VWAY, 0);
        push_exp("lru_dirty", 32'h800, F_DIRTY, 1);
        push_exp("lru_tag", 32'h800, F_TAG, 0);
        push_exp("editmiss_hit", 32'h804, F_HIT, 0);
        push_exp("editmiss_keep", 32'h4, F_DOUT, 32'h1111AAAA);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
    endtask

    task automatic test_priority();
        op(0, 1, 0, 1, 32'h0, 32'h33333333, 4'h0);
        push_exp("inv_hit", 32'h0, F_HIT, 0);
        push_exp("inv_victim", 32'h0, F_VWAY, 0);
        push_exp("inv_valid", 32'h0, F_VALID, 0);
        push_exp("inv_dirty", 32'h0, F_DIRTY, 0);
        push_exp("inv_tag", 32'h0, F_TAG, 0);
        push_exp("inv_other_way", 32'h404, F_HWAY, 1);
        push_exp("inv_other_dout", 32'h404, F_DOUT, 32'h22222222);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
        op(0, 0, 1, 0, 32'h0, 32'hFFFFFFFF, 4'hF);
        push_exp("edit_miss_hit", 32'h0, F_HIT, 0);
        push_exp("edit_miss_dirty", 32'h0, F_DIRTY, 0);
        op(0, 1, 0, 0, 32'h800, 32'h44444444, 4'h0);
        push_exp("refill_way", 32'h800, F_HWAY, 0);
        push_exp("refill_dout", 32'h800, F_DOUT, 32'h44444444);
        push_exp("refill_dirty", 32'h800, F_DIRTY, 0);
        push_exp("next_victim", 32'hC00, F_VWAY, 1);
        push_exp("next_tag", 32'hC00, F_TAG, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        op(0, 1, 0, 0, 32'h010, 32'hA0A0A0A0, 4'h0);
        op(0, 1, 0, 0, 32'h410, 32'hB0B0B0B0, 4'h0);
        op(1, 0, 0, 0, 32'h010, 32'h0, 4'h0);
        op(0, 0, 1, 0, 32'h410, 32'hC0C0C0C0, 4'hF);
        push_exp("b2b_victim", 32'h810, F_VWAY, 0);
        push_exp("b2b_vdirty", 32'h810, F_DIRTY, 0);
        push_exp("b2b_edit_way", 32'h410, F_HWAY, 1);
        push_exp("b2b_edit_dout", 32'h410, F_DOUT, 32'hC0C0C0C0);
        push_exp("b2b_edit_dirty", 32'h410, F_DIRTY, 1);
        push_exp("b2b_first_dout", 32'h010, F_DOUT, 32'hA0A0A0A0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
        op(0, 1, 1, 0, 32'h014, 32'h12345678, 4'b0001);
        push_exp("load_over_edit", 32'h014, F_DOUT, 32'h12345678);
        push_exp("load_over_edit_dirty", 32'h014, F_DIRTY, 0);
        push_exp("load_touch_victim", 32'h810, F_VWAY, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
    endtask

    task automatic test_async_reset();
        op(0, 1, 0, 0, 32'h020, 32'h55555555, 4'h0);
        @(negedge clk);
        addr = 32'h024; din = 32'h66666666; load = 1;
        #1; checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL burst_hit_before_rst: got %b expected 1", hit);
        end
        #1; rst = 0;
        #1; checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL async_hit_drop: got %b expected 0", hit);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL async_valid_drop: got %b expected 0", valid);
        end
        @(posedge clk);
        #1; load = 0;
        @(negedge clk);
        rst = 1;
        push_exp("post_rst_hit", 32'h020, F_HIT, 0);
        push_exp("post_rst_valid", 32'h024, F_VALID, 0);
        push_exp("post_rst_set0", 32'h400, F_HIT, 0);
        push_exp("post_rst_set1", 32'h410, F_HIT, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; checks++;
            if (observe(e.field) !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observe(e.field), e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fills();
        test_edit();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised N-way set-associative cache storage array with per-set true-LRU replacement, multi-word lines and byte-enabled writes. It is the successor to the single-way cache array in the pipelined MIPS core's memory stage. Lookup is combinational; all state changes happen on the clock edge. On a miss it reports the victim way's valid, dirty and tag so the cache controller can write the line back and refill it.

## Interface
- ADDR_BITS, 32: address width (from mips_define.vh).
- WORD_BITS, 32: data word width.
- WAYS, 2: associativity; power of two, 1–8.
- SET_NUM, 64: sets; power of two.
- LINE_WORDS, 4: words per line; power of two.
- Derived values:
  - OFS_BITS = log2(LINE_WORDS).
  - IDX_BITS = log2(SET_NUM).
  - TAG_BITS = ADDR_BITS − IDX_BITS − OFS_BITS − 2.
  - Address fields: tag = addr[ADDR_BITS-1 -: TAG_BITS], index next, then word offset; addr[1:0] is ignored.
- clk  in  1  clock; all writes occur on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_BITS  lookup/write address.
- read  in  1  read access; on a hit, the hit way becomes MRU.
- load  in  1  fill one word: writes din, tag, valid=1, dirty=0.
- edit  in  1  write on hit under wstrb; sets dirty=1.
- invalid  in  1  on a hit, clears valid and dirty of the hit way.
- wstrb  in  WORD_BITS/8  byte enables for edit (load always writes the full word).
- din  in  WORD_BITS  write data.
- hit  out  1  the addressed tag is valid in some way of the indexed set.
- hit_way  out  log2(WAYS) (min 1)  matching way; 0 on a miss.
- victim_way  out  log2(WAYS) (min 1)  way a load would target on a miss.
- dout  out  WORD_BITS  addressed word of the hit way; 0 on a miss.
- valid, dirty  out  1  state of the selected way: hit_way on a hit, victim_way on a miss.
- tag  out  TAG_BITS  stored tag of the selected way; 0 when valid=0.

## Operation
- **Lookup** (combinational): compare the tag against all ways of the indexed set. More than one matching valid way is illegal and cannot arise through this interface.
- **Victim selection**:
  - The lowest-index invalid way, if any.
  - Otherwise the way whose age equals WAYS−1.
- **Per-set LRU state**: one age counter of log2(WAYS) bits per way, always a permutation of 0..WAYS−1.
  - Touching way w with age a: every way with age < a increments, and w becomes 0.
- **Priority** when several strobes are high in one cycle: invalid > load > edit > read. Only the winning operation takes effect.
- **load**:
  - Target is hit_way on a hit, else victim_way.
  - Writes din into the addressed word, writes tag, sets valid=1, clears dirty, and touches the target way.
  - A multi-word fill is done one word per cycle. After the first word the line hits, so the remaining words land in the same way. The controller must complete the burst.
- **edit**:
  - On a hit: bytes with wstrb[i]=1 are replaced, dirty=1, and the hit way is touched.
  - On a miss: no state change.
- **invalid**:
  - On a hit: clear valid and dirty, and make that way LRU (age WAYS−1; ways that were older decrement).
  - On a miss: no effect.
- **read**: on a hit, touch the hit way. On a miss, no state change.
- **Reset**:
  - All valid and dirty bits are cleared.
  - Age of way w = w, so way WAYS−1 is LRU.
  - Data and tag arrays are not reset.
  - Resulting outputs: hit=0, dout=0, valid=0, dirty=0, tag=0, hit_way=0, victim_way=0.

## Timing
- Outputs are combinational from addr and the stored state; there are zero cycles of lookup latency.
- Writes take effect at the rising edge and are visible in the outputs immediately after that edge.
- Reset asserted mid-operation:
  - Outputs go to their reset values asynchronously, without waiting for a clock edge.
  - A strobe in the same cycle is discarded.
- Releasing reset: the first write occurs at the first rising edge with rst=1.
- Back-to-back operations on the same set in consecutive cycles must see the updated state and ages.

## Structure
- ADDR_BITS, WORD_BITS and the field-extraction macros stay in mips_define.vh. TAG_BITS is derived locally from the parameters.
- Sub-module cache_lru holds the age counters for one indexed set. It has these ports:
  - Inputs: touch, touch_way, demote, demote_way.
  - Output: lru_way.
  - It is replicated or arrayed across sets.
- Data, tag, valid and dirty arrays are plain register arrays in cache_assoc.

## Test plan
Defaults are used throughout: 2 ways, 64 sets, 4 words per line. Index is addr[9:4] and tag is addr[31:10].

1. **Reset**: pulse rst=0, then read 0x0 → hit=0, valid=0, dirty=0, tag=0, victim_way=0, dout=0.
2. **First fill**: load with din=0x11111111 at 0x0, 0x4, 0x8, 0xC → read 0x8 gives hit=1, hit_way=0, dout=0x11111111, dirty=0.
3. **Second fill**: load 0x22222222 at 0x400..0x40C → fills way 1. Then:
   - read 0x0 → hit, hit_way=0.
   - Lookup 0x800 → hit=0, victim_way=1, valid=1, tag=0x1.
4. **Byte-enabled edit**: edit 0x4 with wstrb=0011 and din=0xAAAAAAAA → dout=0x1111AAAA, dirty=1. Then read 0x400 and look up 0x800 → victim_way=0, dirty=1, tag=0.
5. **Simultaneous strobes**: assert invalid and load together at 0x0 → invalid wins: hit=0, victim_way=0, valid=0. A following edit at a missing address changes nothing.
6. **Async reset mid-burst**: assert rst=0 between clock edges during a fill → hit and valid drop before the next edge, and the line does not hit afterward.
